// File: rtl/sort_pkg.sv
// Shared types and constants for the RAM bubble-sort sequencer.
package sort_pkg;

  localparam int SWAP_CNT_W = 16;

  typedef enum logic [2:0] {
    IDLE,
    RD_A,
    RD_B,
    CMP,
    WR_A,
    WR_B,
    FIN
  } sort_state_t;

endpackage

// File: rtl/sort_cmp.sv
// Unsigned element comparator: flags when a pair is out of order.
module sort_cmp #(
  parameter int DATA_WIDTH = 8,
  parameter int DESCEND    = 0
) (
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic                  swap_needed
);

  // Equal values never swap, so the sort stays stable.
  always_comb begin
    if (DESCEND != 0) swap_needed = (a < b);
    else              swap_needed = (a > b);
  end

endmodule

// File: rtl/sort_ctrl.sv
// Bubble-sort sequencer driving a single-port RAM (sync write, async read),
// with early exit on a swap-free pass and swap/pass statistics.
module sort_ctrl
  import sort_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int DESCEND    = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH:0]   len,
  output logic                  busy,
  output logic                  done,
  output logic [SWAP_CNT_W-1:0] swap_cnt,
  output logic [ADDR_WIDTH:0]   pass_cnt,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_din,
  input  logic [DATA_WIDTH-1:0] ram_dout
);

  localparam int              LW  = ADDR_WIDTH + 1;
  localparam logic [LW-1:0]   CAP = LW'(2 ** ADDR_WIDTH);

  sort_state_t           state_q, state_d;
  logic [LW-1:0]         len_q, len_d;
  logic [LW-1:0]         i_q, i_d;
  logic [LW-1:0]         j_q, j_d;
  logic                  swapped_q, swapped_d;
  logic [DATA_WIDTH-1:0] a_q, a_d;
  logic [DATA_WIDTH-1:0] b_q, b_d;
  logic [SWAP_CNT_W-1:0] swap_cnt_q, swap_cnt_d;
  logic [LW-1:0]         pass_cnt_q, pass_cnt_d;

  logic          swap_needed;
  logic          advance;
  logic          swapped_now;
  logic [LW-1:0] len_clamped;

  sort_cmp #(
    .DATA_WIDTH (DATA_WIDTH),
    .DESCEND    (DESCEND)
  ) u_cmp (
    .a           (a_q),
    .b           (b_q),
    .swap_needed (swap_needed)
  );

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge value of every other register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      len_q      <= '0;
      i_q        <= '0;
      j_q        <= '0;
      swapped_q  <= 1'b0;
      a_q        <= '0;
      b_q        <= '0;
      swap_cnt_q <= '0;
      pass_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      i_q        <= i_d;
      j_q        <= j_d;
      swapped_q  <= swapped_d;
      a_q        <= a_d;
      b_q        <= b_d;
      swap_cnt_q <= swap_cnt_d;
      pass_cnt_q <= pass_cnt_d;
    end
  end

  // NOTE: every combinational output is given a default first, so no path
  // through the case statement can leave a latch behind.
  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    i_d         = i_q;
    j_d         = j_q;
    swapped_d   = swapped_q;
    a_d         = a_q;
    b_d         = b_q;
    swap_cnt_d  = swap_cnt_q;
    pass_cnt_d  = pass_cnt_q;
    advance     = 1'b0;
    len_clamped = (len > CAP) ? CAP : len;
    // The WR_B swap must count toward the current pass before deciding exit.
    swapped_now = swapped_q | (state_q == WR_B);

    case (state_q)
      IDLE: begin
        if (start) begin
          len_d      = len_clamped;
          swap_cnt_d = '0;
          pass_cnt_d = '0;
          i_d        = '0;
          j_d        = '0;
          swapped_d  = 1'b0;
          state_d    = (len_clamped < LW'(2)) ? FIN : RD_A;
        end
      end
      RD_A: begin
        a_d     = ram_dout;
        state_d = RD_B;
      end
      RD_B: begin
        b_d     = ram_dout;
        state_d = CMP;
      end
      CMP: begin
        if (swap_needed) state_d = WR_A;
        else             advance = 1'b1;
      end
      WR_A: state_d = WR_B;
      WR_B: begin
        swapped_d = 1'b1;
        if (swap_cnt_q != '1) swap_cnt_d = swap_cnt_q + 1'b1;
        advance   = 1'b1;
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (advance) begin
      if (j_q + 1'b1 < len_q - 1'b1 - i_q) begin
        j_d     = j_q + 1'b1;
        state_d = RD_A;
      end else begin
        pass_cnt_d = pass_cnt_q + 1'b1;
        if (!swapped_now || (i_q + 1'b1 == len_q - 1'b1)) begin
          state_d = FIN;
        end else begin
          i_d       = i_q + 1'b1;
          j_d       = '0;
          swapped_d = 1'b0;
          state_d   = RD_A;
        end
      end
    end
  end

  always_comb begin
    busy     = 1'b0;
    done     = 1'b0;
    ram_we   = 1'b0;
    ram_addr = '0;
    ram_din  = '0;
    case (state_q)
      RD_A: begin
        busy     = 1'b1;
        ram_addr = j_q[ADDR_WIDTH-1:0];
      end
      RD_B: begin
        busy     = 1'b1;
        ram_addr = j_q[ADDR_WIDTH-1:0] + 1'b1;
      end
      CMP:  busy = 1'b1;
      WR_A: begin
        busy     = 1'b1;
        ram_we   = 1'b1;
        ram_addr = j_q[ADDR_WIDTH-1:0];
        ram_din  = b_q;
      end
      WR_B: begin
        busy     = 1'b1;
        ram_we   = 1'b1;
        ram_addr = j_q[ADDR_WIDTH-1:0] + 1'b1;
        ram_din  = a_q;
      end
      FIN:     done = 1'b1;
      default: ;
    endcase
  end

  assign swap_cnt = swap_cnt_q;
  assign pass_cnt = pass_cnt_q;

endmodule

// File: tb/tb_sort_ctrl.sv
// Self-checking bench for sort_ctrl: ascending and descending instances,
// each with its own behavioural RAM, checked against an array-based model.
module tb_sort_ctrl;

  localparam int DW = 8;
  localparam int AW = 4;
  localparam int LW = AW + 1;
  localparam int N  = 2 ** AW;

  logic          clk = 1'b0;
  logic          rst;
  logic          start_a, start_d;
  logic [LW-1:0] len;

  logic          busy_a, done_a, ram_we_a, busy_d, done_d, ram_we_d;
  logic [15:0]   swap_cnt_a, swap_cnt_d;
  logic [LW-1:0] pass_cnt_a, pass_cnt_d;
  logic [AW-1:0] ram_addr_a, ram_addr_d;
  logic [DW-1:0] ram_din_a, ram_din_d, ram_dout_a, ram_dout_d;

  logic [DW-1:0] mem_a [N];
  logic [DW-1:0] mem_d [N];
  logic          load_we_a, load_we_d;
  logic [AW-1:0] load_addr;
  logic [DW-1:0] load_data;

  int n_checks = 0;
  int n_fail   = 0;

  logic [DW-1:0] init_mem [N];
  logic [DW-1:0] ref_mem  [N];
  int ref_swaps, ref_passes, ref_cmps;
  int r_busy, r_done_cyc, r_done_n, r_we, r_post_busy;

  always #5 clk = ~clk;

  sort_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DESCEND(0)) u_asc (
    .clk(clk), .rst(rst), .start(start_a), .len(len),
    .busy(busy_a), .done(done_a), .swap_cnt(swap_cnt_a), .pass_cnt(pass_cnt_a),
    .ram_we(ram_we_a), .ram_addr(ram_addr_a), .ram_din(ram_din_a), .ram_dout(ram_dout_a)
  );

  sort_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DESCEND(1)) u_dsc (
    .clk(clk), .rst(rst), .start(start_d), .len(len),
    .busy(busy_d), .done(done_d), .swap_cnt(swap_cnt_d), .pass_cnt(pass_cnt_d),
    .ram_we(ram_we_d), .ram_addr(ram_addr_d), .ram_din(ram_din_d), .ram_dout(ram_dout_d)
  );

  // Sorting RAMs: synchronous write, asynchronous read; the bench loads them
  // through a side port while the controller is idle.
  always @(posedge clk) begin
    if (ram_we_a)       mem_a[ram_addr_a] <= ram_din_a;
    else if (load_we_a) mem_a[load_addr]  <= load_data;
    if (ram_we_d)       mem_d[ram_addr_d] <= ram_din_d;
    else if (load_we_d) mem_d[load_addr]  <= load_data;
  end
  assign ram_dout_a = mem_a[ram_addr_a];
  assign ram_dout_d = mem_d[ram_addr_d];

  // Reference: plain bubble sort with early exit, on the first min(n,16) entries.
  task automatic model_sort(input bit dsc, input int n);
    int m;
    bit sw;
    logic [DW-1:0] t;
    m = (n > N) ? N : n;
    ref_mem = init_mem;
    ref_swaps = 0; ref_passes = 0; ref_cmps = 0;
    for (int i = 0; i < m - 1; i++) begin
      sw = 1'b0;
      for (int j = 0; j < m - 1 - i; j++) begin
        ref_cmps++;
        if (dsc ? (ref_mem[j] < ref_mem[j+1]) : (ref_mem[j] > ref_mem[j+1])) begin
          t = ref_mem[j]; ref_mem[j] = ref_mem[j+1]; ref_mem[j+1] = t;
          ref_swaps++;
          sw = 1'b1;
        end
      end
      ref_passes++;
      if (!sw) break;
    end
  endtask

  task automatic load_ram(input bit dsc);
    for (int k = 0; k < N; k++) begin
      @(posedge clk); #1;
      load_we_a = !dsc; load_we_d = dsc;
      load_addr = AW'(k); load_data = init_mem[k];
    end
    @(posedge clk); #1;
    load_we_a = 1'b0; load_we_d = 1'b0;
  endtask

  function automatic int ram_diff(input bit dsc);
    int d = 0;
    for (int k = 0; k < N; k++)
      if ((dsc ? mem_d[k] : mem_a[k]) !== ref_mem[k]) d++;
    return d;
  endfunction

  // Starts a sort, counts cycles from the accepting edge, and watches three
  // cycles beyond done. With noise, start and len are toggled while busy.
  task automatic run_sort(input bit dsc, input int n, input bit noise);
    logic b, d, w;
    r_busy = 0; r_done_cyc = 0; r_done_n = 0; r_we = 0; r_post_busy = 0;
    @(posedge clk); #1;
    len = LW'(n);
    if (dsc) start_d = 1'b1; else start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0; start_d = 1'b0;
    if (noise) len = LW'($urandom);
    for (int c = 1; c <= 1500; c++) begin
      @(negedge clk);
      b = dsc ? busy_d : busy_a;
      d = dsc ? done_d : done_a;
      w = dsc ? ram_we_d : ram_we_a;
      if (b) r_busy++;
      if (w) r_we++;
      if (b && r_done_cyc != 0) r_post_busy++;
      if (d) begin
        r_done_n++;
        if (r_done_cyc == 0) r_done_cyc = c;
      end
      if (r_done_cyc != 0 && c >= r_done_cyc + 3) break;
      if (noise) begin
        logic s;
        s = (r_done_cyc == c) ? 1'b1 : ((r_done_cyc == 0) ? 1'($urandom_range(0, 1)) : 1'b0);
        if (dsc) start_d = s; else start_a = s;
        len = LW'($urandom);
      end
    end
    start_a = 1'b0; start_d = 1'b0;
    n_checks++;
    if (r_done_cyc == 0) begin
      n_fail++;
      $display("FAIL timeout: no done pulse within 1500 cycles (dsc=%0d len=%0d)", dsc, n);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start_a = 1'b0; start_d = 1'b0; len = '0;
    load_we_a = 1'b0; load_we_d = 1'b0; load_addr = '0; load_data = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_checks++; if ({busy_a, done_a, ram_we_a} !== 3'b000) begin n_fail++; $display("FAIL reset_ctrl: busy/done/we=%b expected 000", {busy_a, done_a, ram_we_a}); end
    n_checks++; if (ram_addr_a !== '0 || ram_din_a !== '0) begin n_fail++; $display("FAIL reset_bus: addr=%0d din=%0d expected 0 0", ram_addr_a, ram_din_a); end
    n_checks++; if (swap_cnt_a !== '0 || pass_cnt_a !== '0) begin n_fail++; $display("FAIL reset_stats: swap=%0d pass=%0d expected 0 0", swap_cnt_a, pass_cnt_a); end
    n_checks++; if ({busy_d, done_d, ram_we_d} !== 3'b000) begin n_fail++; $display("FAIL reset_dsc: busy/done/we=%b expected 000", {busy_d, done_d, ram_we_d}); end
    rst = 1'b0;
  endtask

  task automatic set_test1_data();
    logic [DW-1:0] t1 [8] = '{8'd90, 8'd25, 8'd60, 8'd15, 8'd30, 8'd75, 8'd45, 8'd10};
    for (int k = 0; k < N; k++) init_mem[k] = (k < 8) ? t1[k] : DW'($urandom);
  endtask

  task automatic test_unsorted();
    logic [DW-1:0] exp8 [8] = '{8'd10, 8'd15, 8'd25, 8'd30, 8'd45, 8'd60, 8'd75, 8'd90};
    int bad = 0;
    set_test1_data();
    load_ram(1'b0);
    model_sort(1'b0, 8);
    run_sort(1'b0, 8, 1'b0);
    for (int k = 0; k < 8; k++) if (mem_a[k] !== exp8[k]) bad++;
    n_checks++; if (bad != 0) begin n_fail++; $display("FAIL t1_sorted: %0d wrong entries expected 0", bad); end
    n_checks++; if (ram_diff(1'b0) != 0) begin n_fail++; $display("FAIL t1_ram: %0d entries differ from model", ram_diff(1'b0)); end
    n_checks++; if (swap_cnt_a !== 16'd18) begin n_fail++; $display("FAIL t1_swaps: got %0d expected 18", swap_cnt_a); end
    n_checks++; if (pass_cnt_a !== LW'(7)) begin n_fail++; $display("FAIL t1_passes: got %0d expected 7", pass_cnt_a); end
    n_checks++; if (r_done_n != 1) begin n_fail++; $display("FAIL t1_done_pulses: got %0d expected 1", r_done_n); end
    n_checks++; if (r_busy != 3 * ref_cmps + 2 * ref_swaps) begin n_fail++; $display("FAIL t1_busy: got %0d expected %0d", r_busy, 3 * ref_cmps + 2 * ref_swaps); end
  endtask

  task automatic test_sorted();
    for (int k = 0; k < N; k++) init_mem[k] = (k < 8) ? DW'(k + 1) : DW'($urandom);
    load_ram(1'b0);
    model_sort(1'b0, 8);
    run_sort(1'b0, 8, 1'b0);
    n_checks++; if (r_we != 0) begin n_fail++; $display("FAIL t2_no_write: ram_we high %0d cycles expected 0", r_we); end
    n_checks++; if (swap_cnt_a !== 16'd0 || pass_cnt_a !== LW'(1)) begin n_fail++; $display("FAIL t2_stats: swap=%0d pass=%0d expected 0 1", swap_cnt_a, pass_cnt_a); end
    n_checks++; if (r_busy != 21) begin n_fail++; $display("FAIL t2_busy: got %0d cycles expected 21", r_busy); end
    n_checks++; if (r_done_cyc != 22) begin n_fail++; $display("FAIL t2_done_cycle: got %0d expected 22", r_done_cyc); end
    n_checks++; if (ram_diff(1'b0) != 0) begin n_fail++; $display("FAIL t2_ram: %0d entries changed", ram_diff(1'b0)); end
  endtask

  task automatic test_descend();
    logic [DW-1:0] exp8 [8] = '{8'd90, 8'd75, 8'd60, 8'd45, 8'd30, 8'd25, 8'd15, 8'd10};
    int bad = 0;
    set_test1_data();
    load_ram(1'b1);
    model_sort(1'b1, 8);
    run_sort(1'b1, 8, 1'b0);
    for (int k = 0; k < 8; k++) if (mem_d[k] !== exp8[k]) bad++;
    n_checks++; if (bad != 0) begin n_fail++; $display("FAIL t3_sorted: %0d wrong entries expected 0", bad); end
    n_checks++; if (swap_cnt_d !== 16'd10) begin n_fail++; $display("FAIL t3_swaps: got %0d expected 10", swap_cnt_d); end
    n_checks++; if (int'(pass_cnt_d) != ref_passes) begin n_fail++; $display("FAIL t3_passes: got %0d expected %0d", pass_cnt_d, ref_passes); end
  endtask

  task automatic test_short_len();
    for (int n = 0; n < 2; n++) begin
      for (int k = 0; k < N; k++) init_mem[k] = DW'($urandom);
      load_ram(1'b0);
      model_sort(1'b0, n);
      run_sort(1'b0, n, 1'b0);
      n_checks++; if (r_done_cyc != 1 || r_busy != 0) begin n_fail++; $display("FAIL t4_len%0d_timing: done_cycle=%0d busy=%0d expected 1 0", n, r_done_cyc, r_busy); end
      n_checks++; if (pass_cnt_a !== '0 || swap_cnt_a !== '0) begin n_fail++; $display("FAIL t4_len%0d_stats: pass=%0d swap=%0d expected 0 0", n, pass_cnt_a, swap_cnt_a); end
      n_checks++; if (ram_diff(1'b0) != 0 || r_we != 0) begin n_fail++; $display("FAIL t4_len%0d_ram: diff=%0d writes=%0d expected 0 0", n, ram_diff(1'b0), r_we); end
    end
    for (int k = 0; k < N; k++) init_mem[k] = DW'($urandom);
    load_ram(1'b0);
    model_sort(1'b0, 31);
    run_sort(1'b0, 31, 1'b0);
    n_checks++; if (ram_diff(1'b0) != 0) begin n_fail++; $display("FAIL t4_clamp_ram: %0d entries differ from model", ram_diff(1'b0)); end
    n_checks++; if (int'(swap_cnt_a) != ref_swaps || int'(pass_cnt_a) != ref_passes) begin n_fail++; $display("FAIL t4_clamp_stats: swap=%0d pass=%0d expected %0d %0d", swap_cnt_a, pass_cnt_a, ref_swaps, ref_passes); end
  endtask

  task automatic test_reset_mid_sort();
    int seen = 0;
    int late_done = 0;
    set_test1_data();
    load_ram(1'b0);
    @(posedge clk); #1;
    len = LW'(8); start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    for (int c = 0; c < 100 && seen == 0; c++) begin
      @(negedge clk);
      if (ram_we_a) seen = 1;
    end
    n_checks++; if (seen == 0) begin n_fail++; $display("FAIL t5_wr_a: ram_we never seen within 100 cycles"); end
    rst = 1'b1;
    @(negedge clk);
    n_checks++; if ({busy_a, ram_we_a, done_a} !== 3'b000) begin n_fail++; $display("FAIL t5_after_reset: busy/we/done=%b expected 000", {busy_a, ram_we_a, done_a}); end
    n_checks++; if (swap_cnt_a !== '0 || pass_cnt_a !== '0) begin n_fail++; $display("FAIL t5_stats: swap=%0d pass=%0d expected 0 0", swap_cnt_a, pass_cnt_a); end
    rst = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (done_a || busy_a) late_done++;
    end
    n_checks++; if (late_done != 0) begin n_fail++; $display("FAIL t5_no_done: %0d cycles with busy/done after reset expected 0", late_done); end
    // The WR_A write of b=25 into entry 0 lands on the reset edge.
    n_checks++; if (mem_a[0] !== 8'd25) begin n_fail++; $display("FAIL t5_partial: entry0=%0d expected 25", mem_a[0]); end
    for (int k = 0; k < N; k++) init_mem[k] = mem_a[k];
    model_sort(1'b0, 8);
    run_sort(1'b0, 8, 1'b0);
    n_checks++; if (ram_diff(1'b0) != 0 || r_done_n != 1) begin n_fail++; $display("FAIL t5_resort: diff=%0d done_pulses=%0d expected 0 1", ram_diff(1'b0), r_done_n); end
  endtask

  task automatic test_back_to_back();
    set_test1_data();
    load_ram(1'b0);
    model_sort(1'b0, 8);
    run_sort(1'b0, 8, 1'b1);
    n_checks++; if (ram_diff(1'b0) != 0) begin n_fail++; $display("FAIL t6_ram: %0d entries differ from model", ram_diff(1'b0)); end
    n_checks++; if (swap_cnt_a !== 16'd18 || pass_cnt_a !== LW'(7)) begin n_fail++; $display("FAIL t6_stats: swap=%0d pass=%0d expected 18 7", swap_cnt_a, pass_cnt_a); end
    n_checks++; if (r_done_n != 1 || r_post_busy != 0) begin n_fail++; $display("FAIL t6_restart: done_pulses=%0d busy_after_done=%0d expected 1 0", r_done_n, r_post_busy); end
  endtask

  task automatic test_random();
    for (int it = 0; it < 8; it++) begin
      bit dsc;
      int n;
      dsc = 1'($urandom_range(0, 1));
      n = $urandom_range(0, 20);
      for (int k = 0; k < N; k++)
        init_mem[k] = (it % 2 == 1) ? DW'($urandom_range(0, 7)) : DW'($urandom);
      load_ram(dsc);
      model_sort(dsc, n);
      run_sort(dsc, n, 1'b0);
      n_checks++; if (ram_diff(dsc) != 0) begin n_fail++; $display("FAIL rnd%0d_ram: %0d entries differ (dsc=%0d len=%0d)", it, ram_diff(dsc), dsc, n); end
      n_checks++;
      if (int'(dsc ? swap_cnt_d : swap_cnt_a) != ref_swaps || int'(dsc ? pass_cnt_d : pass_cnt_a) != ref_passes) begin
        n_fail++;
        $display("FAIL rnd%0d_stats: swap=%0d pass=%0d expected %0d %0d", it,
                 dsc ? swap_cnt_d : swap_cnt_a, dsc ? pass_cnt_d : pass_cnt_a, ref_swaps, ref_passes);
      end
      n_checks++; if (r_done_cyc != 3 * ref_cmps + 2 * ref_swaps + 1) begin n_fail++; $display("FAIL rnd%0d_timing: done_cycle=%0d expected %0d", it, r_done_cyc, 3 * ref_cmps + 2 * ref_swaps + 1); end
    end
  endtask

  initial begin
    test_reset();
    test_unsorted();
    test_sorted();
    test_descend();
    test_short_len();
    test_reset_mid_sort();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
